pipeline_destino: RTL

Parametrised successor to the destination-register multiplexer. It selects the write-back destination (rd, rt, link register or none), then carries it and its write-enable through PIPE_DEPTH pipeline stages. The final stage drives the register-file write port. It also flags RAW hazards between the source registers of the instruction being decoded and every in-flight destination. It sits between decode and the register-file write-back port.

---
 rtl/pacote_processador_pkg.sv | 13 +
 rtl/estagio_destino.sv | 26 ++
 rtl/pipeline_destino.sv | 107 ++++++++++
 3 files changed

// File: rtl/pacote_processador_pkg.sv
// Shared register-file constants and destination-select encodings for the
// decode/write-back path.
package pacote_processador;

  localparam int REG_ADDR_W = 5;
  localparam int LINK_REG   = 30;

  localparam logic [1:0] DEST_RD     = 2'b00;
  localparam logic [1:0] DEST_RT     = 2'b01;
  localparam logic [1:0] DEST_LINK   = 2'b10;
  localparam logic [1:0] DEST_NENHUM = 2'b11;

endpackage

// File: rtl/estagio_destino.sv
// One in-flight destination slot: {valido, destino} with hold, clear and load.
module estagio_destino #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic         limpa,
  input  logic         valido_in,
  input  logic [W-1:0] destino_in,
  output logic         valido,
  output logic [W-1:0] destino
);

  // Clear wins over load so a flushed slot never keeps a stale entry.
  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      valido  <= 1'b0;
      destino <= '0;
    end else if (carrega) begin
      valido  <= valido_in;
      destino <= destino_in;
    end
  end

endmodule

// File: rtl/pipeline_destino.sv
// Write-back destination selector, carried through PIPE_DEPTH stages, with
// RAW-hazard detection against every in-flight destination except write-back.
module pipeline_destino #(
  parameter int REG_ADDR_W   = pacote_processador::REG_ADDR_W,
  parameter int LINK_REG     = pacote_processador::LINK_REG,
  parameter int PIPE_DEPTH   = 3,
  parameter int FLUSH_STAGES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  entrada_valida,
  input  logic [1:0]            tipo_destino,
  input  logic [REG_ADDR_W-1:0] reg_rd,
  input  logic [REG_ADDR_W-1:0] reg_rt,
  input  logic [REG_ADDR_W-1:0] fonte_a,
  input  logic [REG_ADDR_W-1:0] fonte_b,
  input  logic                  usa_fonte_b,
  input  logic                  parada,
  input  logic                  limpa,
  output logic [REG_ADDR_W-1:0] destino_wb,
  output logic                  escreve_wb,
  output logic [REG_ADDR_W-1:0] destino_atual,
  output logic                  perigo,
  output logic [3:0]            ocupacao
);
  import pacote_processador::DEST_RD;
  import pacote_processador::DEST_RT;
  import pacote_processador::DEST_LINK;
  import pacote_processador::DEST_NENHUM;

  logic                  valido_st   [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] destino_st  [PIPE_DEPTH];
  logic                  valido_prox [PIPE_DEPTH];
  logic                  escreve_in;
  logic [3:0]            ocupacao_prox;
  logic [3:0]            ocupacao_q;

  always_comb begin
    case (tipo_destino)
      DEST_RD:   destino_atual = reg_rd;
      DEST_RT:   destino_atual = reg_rt;
      DEST_LINK: destino_atual = REG_ADDR_W'(LINK_REG);
      default:   destino_atual = '0;
    endcase
  end

  // Register 0 is hardwired, so writes to it are never tracked.
  assign escreve_in = entrada_valida && (tipo_destino != DEST_NENHUM) &&
                      (destino_atual != '0);

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_estagio
    logic                  valido_ant;
    logic [REG_ADDR_W-1:0] destino_ant;
    logic                  limpa_local;

    if (i == 0) begin : g_entrada
      assign valido_ant  = escreve_in;
      assign destino_ant = destino_atual;
    end else begin : g_cadeia
      assign valido_ant  = valido_st[i-1];
      assign destino_ant = destino_st[i-1];
    end

    assign limpa_local    = limpa && (i < FLUSH_STAGES);
    assign valido_prox[i] = limpa_local ? 1'b0 : (parada ? valido_st[i] : valido_ant);

    estagio_destino #(.W(REG_ADDR_W)) u_estagio (
      .clock      (clock),
      .reset      (reset),
      .carrega    (!parada),
      .limpa      (limpa_local),
      .valido_in  (valido_ant),
      .destino_in (destino_ant),
      .valido     (valido_st[i]),
      .destino    (destino_st[i])
    );
  end

  always_comb begin
    ocupacao_prox = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      ocupacao_prox = ocupacao_prox + 4'(valido_prox[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ocupacao_q <= '0;
    else       ocupacao_q <= ocupacao_prox;
  end

  assign ocupacao = ocupacao_q;

  // Write-back stage is excluded: the register file writes before it reads.
  always_comb begin
    perigo = 1'b0;
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      if (valido_st[i]) begin
        if ((fonte_a != '0) && (destino_st[i] == fonte_a)) perigo = 1'b1;
        if (usa_fonte_b && (fonte_b != '0) && (destino_st[i] == fonte_b)) perigo = 1'b1;
      end
    end
  end

  assign escreve_wb = valido_st[PIPE_DEPTH-1];
  assign destino_wb = escreve_wb ? destino_st[PIPE_DEPTH-1] : '0;

endmodule
